// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative MULT/MULTU/DIV/DIVU sequencer and its HI/LO owner.
package mul_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MULT  = OP_MULT,
        MULTU = OP_MULTU,
        DIV   = OP_DIV,
        DIVU  = OP_DIVU
    } muldiv_op_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIX  = ST_FIX
    } muldiv_state_t;

    // Bit 0 of the op code clears for the signed variants, bit 1 selects divide.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_sequencer_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? (~data + {{(WIDTH-1){1'b0}}, 1'b1}) : data;
    end

endmodule

// File: rtl/mul_div_sequencer.sv
// Iterative multiply/divide unit owning HI/LO for the EX stage.
// Optional build macro MULDIV_DIVZERO_EXC_EN: divide-by-zero raises divZeroException and leaves HI/LO untouched.
module mul_div_sequencer
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startMulDiv,
    input  logic [1:0]       opMulDiv,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] dataInHiLo,
    input  logic             readHiLo,
    output logic             busyMulDiv,
    output logic             doneMulDiv,
    output logic             stallMulDiv,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
`ifdef MULDIV_DIVZERO_EXC_EN
    ,
    output logic             divZeroException
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULDIV_DIVZERO_EXC_EN
    logic             exc_q, exc_d;
`endif

    logic             start_signed;
    logic             start_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign start_signed = op_is_signed(opMulDiv);
    assign start_div    = op_is_div(opMulDiv);

    cond_negate #(.WIDTH(WIDTH)) u_mag_a (
        .data   (operandA),
        .negate (start_signed & operandA[WIDTH-1]),
        .result (mag_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_mag_b (
        .data   (operandB),
        .negate (start_signed & operandB[WIDTH-1]),
        .result (mag_b)
    );

    // Shared adder: multiply adds the multiplicand into the upper half, divide subtracts the divisor.
    logic             is_div;
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH+1:0] add_a;
    logic [WIDTH+1:0] add_b;
    logic             add_cin;
    logic [WIDTH+1:0] add_sum;
    logic             div_neg;

    assign is_div      = op_is_div(op_q);
    assign shifted_rem = {acc_hi_q, acc_lo_q[WIDTH-1]};

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (is_div) begin
            add_a   = {1'b0, shifted_rem};
            add_b   = ~{2'b00, opb_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {2'b00, acc_hi_q};
            add_b   = acc_lo_q[0] ? {2'b00, opa_q} : '0;
            add_cin = 1'b0;
        end
    end

    assign add_sum = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
    assign div_neg = add_sum[WIDTH+1];

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .data   ({acc_hi_q, acc_lo_q}),
        .negate (sa_q ^ sb_q),
        .result (prod_fixed)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_quot (
        .data   (acc_lo_q),
        .negate (sa_q ^ sb_q),
        .result (quot_fixed)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .data   (acc_hi_q),
        .negate (sa_q),
        .result (rem_fixed)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_DIVZERO_EXC_EN
        exc_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (writeHi) hi_d = dataInHiLo;
                if (writeLo) lo_d = dataInHiLo;
                if (startMulDiv) begin
                    op_d  = muldiv_op_t'(opMulDiv);
                    sa_d  = start_signed & operandA[WIDTH-1];
                    sb_d  = start_signed & operandB[WIDTH-1];
                    opa_d = mag_a;
                    opb_d = mag_b;
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (start_div && (operandB == '0)) begin
                        dz_d     = 1'b1;
                        acc_hi_d = operandA;
                        acc_lo_d = '1;
                        state_d  = FIX;
                    end else if (start_div) begin
                        acc_hi_d = '0;
                        acc_lo_d = mag_a;
                        state_d  = RUN;
                    end else begin
                        acc_hi_d = '0;
                        acc_lo_d = mag_b;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // Partial remainder stays below the divisor, so WIDTH bits hold it between steps.
                if (is_div) begin
                    acc_hi_d = div_neg ? shifted_rem[WIDTH-1:0] : add_sum[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_neg};
                end else begin
                    acc_hi_d = add_sum[WIDTH:1];
                    acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dz_q) begin
`ifdef MULDIV_DIVZERO_EXC_EN
                    exc_d = 1'b1;
`else
                    hi_d  = acc_hi_q;
                    lo_d  = acc_lo_q;
`endif
                end else if (is_div) begin
                    hi_d = rem_fixed;
                    lo_d = quot_fixed;
                end else begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIVZERO_EXC_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIVZERO_EXC_EN
            exc_q   <= exc_d;
`endif
        end
    end

    // Datapath state is only consumed after a start reloads it, so it carries no reset.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        sa_q     <= sa_d;
        sb_q     <= sb_d;
        dz_q     <= dz_d;
        cnt_q    <= cnt_d;
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        opa_q    <= opa_d;
        opb_q    <= opb_d;
    end

    assign busyMulDiv  = (state_q != IDLE);
    assign doneMulDiv  = done_q;
    assign stallMulDiv = busyMulDiv & (readHiLo | writeHi | writeLo | startMulDiv);
    assign hiOut       = hi_q;
    assign loOut       = lo_q;
`ifdef MULDIV_DIVZERO_EXC_EN
    assign divZeroException = exc_q;
`endif

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer with a result scoreboard and a native-arithmetic reference model.
module tb_mul_div_sequencer;

    logic        clk;
    logic        reset;
    logic        startMulDiv;
    logic [1:0]  opMulDiv;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        writeHi;
    logic        writeLo;
    logic [31:0] dataInHiLo;
    logic        readHiLo;
    logic        busyMulDiv;
    logic        doneMulDiv;
    logic        stallMulDiv;
    logic [31:0] hiOut;
    logic [31:0] loOut;
`ifdef MULDIV_DIVZERO_EXC_EN
    logic        divZeroException;
`endif

    mul_div_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .startMulDiv (startMulDiv),
        .opMulDiv    (opMulDiv),
        .operandA    (operandA),
        .operandB    (operandB),
        .writeHi     (writeHi),
        .writeLo     (writeLo),
        .dataInHiLo  (dataInHiLo),
        .readHiLo    (readHiLo),
        .busyMulDiv  (busyMulDiv),
        .doneMulDiv  (doneMulDiv),
        .stallMulDiv (stallMulDiv),
        .hiOut       (hiOut),
        .loOut       (loOut)
`ifdef MULDIV_DIVZERO_EXC_EN
        ,
        .divZeroException (divZeroException)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin up = 64'(sa * sb); hi = up[63:32]; lo = up[31:0]; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    up = 64'(sq); lo = up[31:0];
                    up = 64'(sr); hi = up[31:0];
                end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    task automatic pop_compare(input string where);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({where, " scoreboard-empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, " hi"}, 64'(hiOut), 64'(e.hi));
            check({e.tag, " lo"}, 64'(loOut), 64'(e.lo));
`ifdef MULDIV_DIVZERO_EXC_EN
            check({e.tag, " exc"}, 64'(divZeroException), 64'(e.exc));
`endif
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic eexc, input int lat);
        exp_t e;
        int   c;
        int   gaps;
        e.tag = tag; e.hi = ehi; e.lo = elo; e.exc = eexc;
        sb_q.push_back(e);
        startMulDiv = 1'b1; opMulDiv = op; operandA = a; operandB = b;
        tick();
        startMulDiv = 1'b0;
        c = 1;
        gaps = 0;
        while (doneMulDiv !== 1'b1 && c < 100) begin
            if (busyMulDiv !== 1'b1) gaps++;
            tick();
            c++;
        end
        check({tag, " latency"}, 64'(c), 64'(lat));
        check({tag, " busy-gaps"}, 64'(gaps), 64'd0);
        check({tag, " busy-at-done"}, 64'(busyMulDiv), 64'd0);
        pop_compare(tag);
    endtask

    task automatic run_model(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mh, ml;
        model(op, a, b, mh, ml);
        run_op(tag, op, a, b, mh, ml, 1'b0, 34);
    endtask

    initial begin
        logic [31:0] mh, ml, lo_hold;
        int          lo_moved, late_done;
        exp_t        e;

        reset = 1'b1; startMulDiv = 1'b0; opMulDiv = 2'b00; operandA = '0; operandB = '0;
        writeHi = 1'b0; writeLo = 1'b0; dataInHiLo = '0; readHiLo = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("reset hi", 64'(hiOut), 64'd0);
        check("reset lo", 64'(loOut), 64'd0);
        check("reset busy", 64'(busyMulDiv), 64'd0);
        check("reset done", 64'(doneMulDiv), 64'd0);
        check("reset stall", 64'(stallMulDiv), 64'd0);

        run_op("mult -3*7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
        run_op("multu max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
        run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        run_op("divu 7/2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 34);
        run_op("div ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);

        writeHi = 1'b1; dataInHiLo = 32'hAAAA0000;
        tick();
        writeHi = 1'b0;
        check("mthi", 64'(hiOut), 64'hAAAA0000);
        writeLo = 1'b1; dataInHiLo = 32'h0000BEEF;
        tick();
        writeLo = 1'b0;
        check("mtlo", 64'(loOut), 64'h0000BEEF);
        check("mtlo keeps hi", 64'(hiOut), 64'hAAAA0000);

`ifdef MULDIV_DIVZERO_EXC_EN
        run_op("div by zero", 2'b10, 32'h12345678, 32'd0, 32'hAAAA0000, 32'h0000BEEF, 1'b1, 2);
`else
        run_op("div by zero", 2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b0, 2);
`endif

        for (int i = 0; i < 4; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 1) ra = -ra;
            if (rb == 0) rb = 32'd1;
            run_model($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        // Busy window: reads, a second start and an MTLO must all stall and change nothing.
        model(2'b00, 32'h00012345, 32'hFFFFFF00, mh, ml);
        e.tag = "stall mult"; e.hi = mh; e.lo = ml; e.exc = 1'b0;
        sb_q.push_back(e);
        lo_hold  = loOut;
        lo_moved = 0;
        late_done = 0;
        for (int c = 0; c <= 40; c++) begin
            readHiLo    = (c >= 5);
            startMulDiv = (c == 0) || (c == 10);
            opMulDiv    = (c == 10) ? 2'b01 : 2'b00;
            operandA    = (c == 10) ? 32'h0000FFFF : 32'h00012345;
            operandB    = (c == 10) ? 32'h00000003 : 32'hFFFFFF00;
            writeLo     = (c == 12);
            dataInHiLo  = 32'h5555AAAA;
            #1;
            if (c == 0 || c == 5 || c == 10 || c == 12 || c == 33 || c == 34 || c == 40)
                check($sformatf("stall c%0d", c), 64'(stallMulDiv), 64'((c >= 5) && (c <= 33)));
            if (c >= 1 && c <= 33 && loOut !== lo_hold) lo_moved++;
            if (c == 34) begin
                check("stall mult done", 64'(doneMulDiv), 64'd1);
                pop_compare("stall mult");
            end
            if (c > 34 && doneMulDiv !== 1'b0) late_done++;
            @(posedge clk);
            #1;
        end
        readHiLo = 1'b0; startMulDiv = 1'b0; writeLo = 1'b0;
        check("lo held while busy", 64'(lo_moved), 64'd0);
        check("no extra done", 64'(late_done), 64'd0);

        // Reset in cycle 10 of a run aborts it without a done pulse.
        startMulDiv = 1'b1; opMulDiv = 2'b00; operandA = 32'd5; operandB = 32'd6;
        tick();
        startMulDiv = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 64'(busyMulDiv), 64'd0);
        check("abort hi", 64'(hiOut), 64'd0);
        check("abort lo", 64'(loOut), 64'd0);
        check("abort done", 64'(doneMulDiv), 64'd0);
        late_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (doneMulDiv !== 1'b0 || busyMulDiv !== 1'b0) late_done++;
            tick();
        end
        check("abort no done", 64'(late_done), 64'd0);

        run_model("post-abort multu", 2'b01, 32'h89ABCDEF, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
- Iterative multi-cycle MULT/MULTU/DIV/DIVU unit and HI/LO register owner for the MIPS pipeline, attached to the EX stage.
- Sequences a shared shift/add-subtract datapath over WIDTH iterations.
- Writes HI/LO and serves MTHI/MTLO.
- Raises a stall to the hazard logic when a later instruction touches HI/LO or the unit while busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- startMulDiv  input  1  start request from EX
- opMulDiv  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operandA  input  WIDTH  rs value (multiplicand or dividend)
- operandB  input  WIDTH  rt value (multiplier or divisor)
- writeHi  input  1  MTHI request
- writeLo  input  1  MTLO request
- dataInHiLo  input  WIDTH  MTHI/MTLO data
- readHiLo  input  1  MFHI/MFLO present in EX
- busyMulDiv  output  1  operation in progress
- doneMulDiv  output  1  one-cycle pulse; HI/LO hold the new result
- stallMulDiv  output  1  stall request to the hazard unit
- hiOut  output  WIDTH  HI register
- loOut  output  WIDTH  LO register

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, hiOut=0, loOut=0, busyMulDiv=0, doneMulDiv=0, stallMulDiv=0. Reset during RUN or FIX aborts the operation, and no done pulse follows.
- FSM states: IDLE, RUN, FIX.
- IDLE + startMulDiv:
  - Latch the operator.
  - For signed ops, latch operand magnitudes (two's complement when MSB is set) and the sign flags sA and sB; unsigned ops latch operands as-is.
  - Clear the iteration counter and go to RUN.
- IDLE + DIV/DIVU with operandB==0: go directly to FIX with HI=operandA and LO={WIDTH{1}}.
- RUN: one iteration per cycle; the counter counts 0..WIDTH-1; after iteration WIDTH-1, go to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- FIX: apply the sign correction, write HI/LO, go to IDLE, and set doneMulDiv=1 for the following cycle.
  - MULT: negate the 2*WIDTH product if sA^sB.
  - DIV: negate the quotient if sA^sB; negate the remainder if sA.
  - Placement: product {HI,LO}; quotient to LO, remainder to HI.
- Latency: start in cycle 0 gives done in cycle WIDTH+2 (34 at the default width). Divide-by-zero gives done in cycle 2.
- busyMulDiv=1 whenever the state is not IDLE. It drops in the same cycle that done is high.
- Overflow case: DIV of most-negative by -1 gives LO=most-negative and HI=0. No trap.
- startMulDiv while busy: ignored; stallMulDiv is raised.
- stallMulDiv = busyMulDiv & (readHiLo | writeHi | writeLo | startMulDiv). This output is combinational.
- MTHI/MTLO:
  - Applied at the clock edge only in IDLE.
  - While busy they are ignored, since the stall holds them upstream.
  - MTHI/MTLO in the same IDLE cycle as start: the write lands, then is overwritten by the result at FIX.
- hiOut/loOut are stable except on MTHI/MTLO edges and the FIX edge.

Optional Feature:
- Macro: MULDIV_DIVZERO_EXC_EN.
- When defined:
  - An extra output divZeroException (1 bit) pulses together with doneMulDiv for DIV/DIVU with divisor 0.
  - HI/LO are left unchanged.
  - Latency is unchanged (done in cycle 2).
- When undefined: the port is absent, and divide-by-zero writes HI=operandA, LO=all-ones as above.

Decomposition:
- Package mul_div_pkg holds:
  - enum muldiv_op_t (MULT, MULTU, DIV, DIVU, 2-bit);
  - enum muldiv_state_t (IDLE, RUN, FIX);
  - the op-encoding constants.
- Sub-module cond_negate (WIDTH param; inputs: data, negate; output: negate ? -data : data).
  - Instantiated for operand magnitude conversion and FIX sign correction.
  - A 2*WIDTH instance serves the product.
- Counter, FSM and accumulators stay in the top module.

Test Plan:
- Reset, then idle 5 cycles -> hiOut=loOut=0, busy=0, done=0, stall=0. Assert reset in cycle 10 of a RUN -> next cycle state IDLE, HI/LO=0, no done pulse.
- MULT A=0xFFFFFFFD (-3), B=7, start in cycle 0 -> busy cycles 1..33, done cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 (A=0xFFFFFFF9, B=2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV A=0x12345678, B=0 -> done cycle 2, HI=0x12345678, LO=0xFFFFFFFF. With MULDIV_DIVZERO_EXC_EN: divZeroException=1 in cycle 2, HI/LO unchanged.
- During RUN, readHiLo=1 in cycles 5..40 -> stall=1 in cycles 5..33, 0 in cycle 34 and later. startMulDiv in cycle 10 with different operands is ignored; the result matches the original operands.
- MTHI 0xAAAA0000 in IDLE -> hiOut=0xAAAA0000 next cycle. writeLo during busy -> stall=1 and loOut is unchanged until FIX.
